// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video constants, pattern encodings and timing defaults
package video_pkg;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'b00,
    PAT_GRID  = 2'b01,
    PAT_GRAD  = 2'b10,
    PAT_SOLID = 2'b11
  } pattern_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // 1280x720 timing
  localparam int DEF_H_DISP    = 1280;
  localparam int DEF_H_FRONT   = 110;
  localparam int DEF_H_SYNC    = 40;
  localparam int DEF_H_BACK    = 220;
  localparam int DEF_V_DISP    = 720;
  localparam int DEF_V_FRONT   = 5;
  localparam int DEF_V_SYNC    = 5;
  localparam int DEF_V_BACK    = 20;
  localparam int DEF_CNT_WIDTH = 12;

  // Index 8 and above is the remainder region past the last full bar.
  function automatic logic [15:0] bar_color(input logic [3:0] idx);
    case (idx)
      4'd0:    bar_color = RGB_WHITE;
      4'd1:    bar_color = RGB_YELLOW;
      4'd2:    bar_color = RGB_CYAN;
      4'd3:    bar_color = RGB_GREEN;
      4'd4:    bar_color = RGB_MAGENTA;
      4'd5:    bar_color = RGB_RED;
      4'd6:    bar_color = RGB_BLUE;
      default: bar_color = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// rtl/video_pattern_gen_if.sv - video output bundle (sync, enable, pixel data)
interface video_pattern_gen_if;
  logic        vo_vs;
  logic        vo_hs;
  logic        vo_de;
  logic        vo_sof;
  logic [15:0] vo_data;

  modport master (output vo_vs, vo_hs, vo_de, vo_sof, vo_data);
  modport slave  (input  vo_vs, vo_hs, vo_de, vo_sof, vo_data);
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - h/v counters, region decode, run FSM and frame counter
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_DISP    = DEF_H_DISP,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISP    = DEF_V_DISP,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       de_c,
  output logic       hs_c,
  output logic       vs_c,
  output logic       frame_start,
  output logic       frame_end,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;

  run_state_e           state, state_next;
  logic [CNT_WIDTH-1:0] h_cnt, v_cnt;
  logic                 running, h_last, v_last;

  assign running     = (state == ST_RUN);
  assign h_last      = (h_cnt == CNT_WIDTH'(H_TOTAL - 1));
  assign v_last      = (v_cnt == CNT_WIDTH'(V_TOTAL - 1));
  assign frame_start = running && (h_cnt == '0) && (v_cnt == '0);
  assign frame_end   = running && h_last && v_last;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // en is only honoured on the last clock of a frame, so frames are never cut short
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (en) state_next = ST_RUN;
      ST_RUN:  if (frame_end && !en) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !running) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            frame_cnt <= '0;
    else if (frame_end) frame_cnt <= frame_cnt + 8'd1;
  end

  always_comb begin
    de_c = running && (h_cnt < CNT_WIDTH'(H_DISP)) && (v_cnt < CNT_WIDTH'(V_DISP));
    hs_c = running && (h_cnt >= CNT_WIDTH'(H_DISP + H_FRONT))
                   && (h_cnt <  CNT_WIDTH'(H_DISP + H_FRONT + H_SYNC));
    vs_c = running && (v_cnt >= CNT_WIDTH'(V_DISP + V_FRONT))
                   && (v_cnt <  CNT_WIDTH'(V_DISP + V_FRONT + V_SYNC));
  end

  // Patterns only look at the low coordinate bits
  assign x = h_cnt[7:0];
  assign y = v_cnt[7:0];

endmodule

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - frame-timed RGB565 test pattern source
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_DISP    = DEF_H_DISP,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISP    = DEF_V_DISP,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [15:0]         solid_color,
  video_pattern_gen_if.master vo,
  output logic [7:0]          frame_cnt
);

  localparam int BAR_W = H_DISP / 8;

  logic [7:0]           x, y;
  logic                 de_c, hs_c, vs_c, frame_start;
  pattern_e             mode_q, mode_eff;
  logic [15:0]          color_q, color_eff, pix;
  logic [CNT_WIDTH-1:0] bar_pos;
  logic [3:0]           bar_idx;
  logic [7:0]           grad_sum;

  video_timing_gen #(
    .H_DISP(H_DISP), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_DISP(V_DISP), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .x           (x),
    .y           (y),
    .de_c        (de_c),
    .hs_c        (hs_c),
    .vs_c        (vs_c),
    .frame_start (frame_start),
    .frame_end   (),
    .frame_cnt   (frame_cnt)
  );

  // Pixel (0,0) must already use the values being latched on that same clock
  assign mode_eff  = frame_start ? pattern_e'(mode) : mode_q;
  assign color_eff = frame_start ? solid_color : color_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= PAT_BARS;
      color_q <= RGB_BLACK;
    end else if (frame_start) begin
      mode_q  <= pattern_e'(mode);
      color_q <= solid_color;
    end
  end

  // Bar index tracks x in steps of BAR_W; it parks at 8 for the remainder pixels
  always_ff @(posedge clk) begin
    if (rst || !de_c) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (bar_pos == CNT_WIDTH'(BAR_W - 1)) begin
      bar_pos <= '0;
      bar_idx <= (bar_idx == 4'd8) ? 4'd8 : bar_idx + 4'd1;
    end else begin
      bar_pos <= bar_pos + 1'b1;
    end
  end

  assign grad_sum = x + frame_cnt;

  always_comb begin
    pix = RGB_BLACK;
    case (mode_eff)
      PAT_BARS:  pix = bar_color(bar_idx);
      PAT_GRID:  pix = ((x[4:0] == 5'd0) || (y[4:0] == 5'd0)) ? RGB_WHITE : RGB_BLACK;
      PAT_GRAD:  pix = {grad_sum[7:3], y[7:2], 5'h10};
      PAT_SOLID: pix = color_eff;
      default:   pix = RGB_BLACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vo.vo_vs   <= 1'b0;
      vo.vo_hs   <= 1'b0;
      vo.vo_de   <= 1'b0;
      vo.vo_sof  <= 1'b0;
      vo.vo_data <= '0;
    end else begin
      vo.vo_vs   <= vs_c;
      vo.vo_hs   <= hs_c;
      vo.vo_de   <= de_c;
      vo.vo_sof  <= frame_start;
      vo.vo_data <= de_c ? pix : 16'h0000;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - scoreboard bench for video_pattern_gen on a small raster
module tb_video_pattern_gen;
  import video_pkg::*;

  localparam int HD = 16, HF = 2, HS = 2, HB = 2;
  localparam int VD = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic        sof;
    logic [15:0] data;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] solid_color = 16'h0000;
  logic [7:0]  frame_cnt;

  video_pattern_gen_if vo();

  video_pattern_gen #(
    .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CNT_WIDTH(12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .solid_color (solid_color),
    .vo          (vo.master),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  out_t exp_q[$];
  int tests = 0;
  int fails = 0;

  bit          m_run = 1'b0;
  int          m_t = 0;
  int          m_fc = 0;
  logic [1:0]  m_mode = 2'b00;
  logic [15:0] m_col = 16'h0000;

  function automatic logic [15:0] ref_pix(input logic [1:0] md, input logic [15:0] col,
                                          input int x, input int y, input int fc);
    int bi, r, g;
    logic [4:0] r5;
    logic [5:0] g6;
    case (md)
      2'b00: begin
        bi = x / (HD / 8);
        return (bi < 8) ? bars[bi] : 16'h0000;
      end
      2'b01: return (((x % 32) == 0) || ((y % 32) == 0)) ? 16'hFFFF : 16'h0000;
      2'b10: begin
        r  = (((x % 256) + fc) % 256) / 8;
        g  = (y % 256) / 4;
        r5 = 5'(r);
        g6 = 6'(g);
        return {r5, g6, 5'h10};
      end
      default: return col;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Predict the next registered output from the pre-edge model state, clock once, compare.
  task automatic step();
    out_t e, got;
    int h, v;
    e = '0;
    if (!rst && m_run) begin
      h = m_t % HT;
      v = m_t / HT;
      if (m_t == 0) begin
        m_mode = mode;
        m_col  = solid_color;
      end
      e.de  = (h < HD) && (v < VD);
      e.hs  = (h >= HD + HF) && (h < HD + HF + HS);
      e.vs  = (v >= VD + VF) && (v < VD + VF + VS);
      e.sof = (m_t == 0);
      if (e.de) e.data = ref_pix(m_mode, m_col, h, v, m_fc);
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_fc = 0; m_mode = 2'b00; m_col = 16'h0000;
    end else if (!m_run) begin
      if (en) begin m_run = 1'b1; m_t = 0; end
    end else if (m_t == FT - 1) begin
      m_fc = (m_fc + 1) % 256;
      m_t  = 0;
      if (!en) m_run = 1'b0;
    end else begin
      m_t++;
    end
    #1;
    got = {vo.vo_vs, vo.vo_hs, vo.vo_de, vo.vo_sof, vo.vo_data};
    e = exp_q.pop_front();
    tests++;
    assert (got === e) else begin
      fails++;
      $error("FAIL outputs t=%0d observed=%h expected=%h", m_t, got, e);
    end
    tests++;
    assert (frame_cnt === 8'(m_fc)) else begin
      fails++;
      $error("FAIL frame_cnt observed=%0d expected=%0d", frame_cnt, m_fc);
    end
  endtask

  task automatic wait_sof();
    int n = 0;
    while (vo.vo_sof !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check("sof_wait", 32'(vo.vo_sof), 32'd1);
  endtask

  initial begin
    int de_n, hs_n, vs_n, sof_n, vs_first, n;

    rst = 1'b1;
    step();
    step();
    check("reset_outputs", {27'd0, vo.vo_vs, vo.vo_hs, vo.vo_de, vo.vo_sof, 1'b0}, 32'd0);
    check("reset_data", 32'(vo.vo_data), 32'd0);
    check("reset_fcnt", 32'(frame_cnt), 32'd0);

    // Frame timing and colour bars over one full frame
    rst = 1'b0; en = 1'b1; mode = PAT_BARS;
    wait_sof();
    de_n = 0; hs_n = 0; vs_n = 0; sof_n = 0; vs_first = -1;
    for (int i = 0; i < FT; i++) begin
      if (i > 0) step();
      de_n  += int'(vo.vo_de);
      hs_n  += int'(vo.vo_hs);
      vs_n  += int'(vo.vo_vs);
      sof_n += int'(vo.vo_sof);
      if (vo.vo_vs && vs_first < 0) vs_first = i;
      if (i < HD) check("bar_line0", 32'(vo.vo_data), 32'(bars[i / 2]));
      if (i == HD) check("blank_data", 32'(vo.vo_data), 32'd0);
    end
    check("de_per_frame", 32'(de_n), 32'(HD * VD));
    check("hs_per_frame", 32'(hs_n), 32'(HS * VT));
    check("vs_per_frame", 32'(vs_n), 32'(HT * VS));
    check("sof_per_frame", 32'(sof_n), 32'd1);
    check("vs_offset", 32'(vs_first), 32'(HT * (VD + VF)));

    // Mid-frame mode change takes effect only at the next frame
    for (int i = 0; i < 50; i++) step();
    mode = PAT_SOLID; solid_color = 16'hF800;
    wait_sof();
    check("solid_after_latch", 32'(vo.vo_data), 32'hF800);

    // Gradient after 3 completed frames
    rst = 1'b1; mode = PAT_GRAD;
    step();
    rst = 1'b0;
    wait_sof();
    for (int k = 0; k < 3; k++) begin
      step();
      wait_sof();
    end
    check("grad_fcnt", 32'(frame_cnt), 32'd3);
    for (int i = 0; i < 5; i++) step();
    check("grad_x5", 32'(vo.vo_data), 32'h0810);

    // Stop at line 2: frame completes, then quiet
    rst = 1'b1; mode = PAT_BARS;
    step();
    rst = 1'b0;
    wait_sof();
    de_n = 1;
    for (int i = 0; i < 2 * HT; i++) begin step(); de_n += int'(vo.vo_de); end
    en = 1'b0;
    for (int i = 0; i < 200; i++) begin step(); de_n += int'(vo.vo_de); end
    check("stop_full_frame", 32'(de_n), 32'(HD * VD));
    check("stop_fcnt", 32'(frame_cnt), 32'd1);
    check("stop_idle", {28'd0, vo.vo_vs, vo.vo_hs, vo.vo_de, vo.vo_sof}, 32'd0);
    en = 1'b1;
    step();
    check("restart_sof_early", 32'(vo.vo_sof), 32'd0);
    step();
    check("restart_sof", 32'(vo.vo_sof), 32'd1);

    // Reset at h=7, v=1
    n = 0;
    while (m_t != HT + 7 && n < 500) begin step(); n++; end
    check("reach_h7v1", 32'(m_t), 32'(HT + 7));
    rst = 1'b1;
    step();
    check("midrst_outputs", {27'd0, vo.vo_vs, vo.vo_hs, vo.vo_de, vo.vo_sof, 1'b0}, 32'd0);
    check("midrst_data", 32'(vo.vo_data), 32'd0);
    check("midrst_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    step();
    check("midrst_sof_early", 32'(vo.vo_sof), 32'd0);
    step();
    check("midrst_restart_sof", 32'(vo.vo_sof), 32'd1);
    check("midrst_restart_data", 32'(vo.vo_data), 32'hFFFF);

    // frame_cnt wrap 255 -> 0
    n = 0;
    while (frame_cnt !== 8'd255 && n < 256 * FT) begin step(); n++; end
    check("fcnt_255", 32'(frame_cnt), 32'd255);
    n = 0;
    while (frame_cnt === 8'd255 && n < 2 * FT) begin step(); n++; end
    check("fcnt_wrap", 32'(frame_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
